// File: rtl/uart_xmtr.sv
// UART transmitter: double-buffered holding register feeding a start/data/stop
// shift register, paced by samples_per_bit Sample_clk cycles per serial bit.
module uart_xmtr #(
    parameter int word_size       = 8,
    parameter int samples_per_bit = 8
) (
    input  logic                 Sample_clk,
    input  logic                 rst_b,
    input  logic [word_size-1:0] Data_bus,
    input  logic                 Load_XMT_datareg,
    input  logic                 Byte_ready,
    output logic                 Serial_out,
    output logic                 XMT_busy,
    output logic                 XMT_done
);

    localparam int SCW = (samples_per_bit > 1) ? $clog2(samples_per_bit) : 1;
    localparam int FW  = word_size + 2;
    localparam logic [SCW-1:0] LAST_SAMPLE = SCW'(samples_per_bit - 1);
    localparam logic [SCW-1:0] SAMPLE_ONE  = SCW'(1);
    localparam logic [3:0]     LAST_BIT    = 4'(word_size + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAITING = 2'b01,
        SENDING = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    state_e               state_q, state_d;
    logic [word_size-1:0] xmt_datareg_q, xmt_datareg_d;
    logic [FW-1:0]        shift_q, shift_d;
    logic [SCW-1:0]       sample_q, sample_d;
    logic [3:0]           bit_q, bit_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Next-state, holding-register and frame-shifter logic.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        sample_d = sample_q;
        bit_d    = bit_q;
        done_d   = 1'b0;

        if (Load_XMT_datareg) begin
            xmt_datareg_d = Data_bus;
        end else begin
            xmt_datareg_d = xmt_datareg_q;
        end

        case (state_q)
            IDLE: begin
                shift_d  = {FW{1'b1}};
                sample_d = {SCW{1'b0}};
                bit_d    = 4'd0;
                if (Byte_ready) begin
                    state_d = WAITING;
                end else begin
                    state_d = IDLE;
                end
            end
            WAITING: begin
                // The frame is captured from the holding register as it stands now,
                // so a load on this same edge only affects the following frame.
                shift_d  = {1'b1, xmt_datareg_q, 1'b0};
                sample_d = {SCW{1'b0}};
                bit_d    = 4'd0;
                state_d  = SENDING;
            end
            SENDING: begin
                if (sample_q == LAST_SAMPLE) begin
                    sample_d = {SCW{1'b0}};
                    if (bit_q == LAST_BIT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        shift_d = {FW{1'b1}};
                        bit_d   = 4'd0;
                    end else begin
                        state_d = SENDING;
                        shift_d = {1'b1, shift_q[FW-1:1]};
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    sample_d = sample_q + SAMPLE_ONE;
                end
            end
            default: begin
                state_d  = IDLE;
                shift_d  = {FW{1'b1}};
                sample_d = {SCW{1'b0}};
                bit_d    = 4'd0;
            end
        endcase

        busy_d = (state_d == WAITING) || (state_d == SENDING);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge Sample_clk) begin
        if (rst_b) begin
            state_q       <= IDLE;
            xmt_datareg_q <= {word_size{1'b0}};
            shift_q       <= {FW{1'b1}};
            sample_q      <= {SCW{1'b0}};
            bit_q         <= 4'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            xmt_datareg_q <= xmt_datareg_d;
            shift_q       <= shift_d;
            sample_q      <= sample_d;
            bit_q         <= bit_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign Serial_out = shift_q[0];
    assign XMT_busy   = busy_q;
    assign XMT_done   = done_q;

endmodule

// File: tb/tb_uart_xmtr.sv
// Bench for uart_xmtr: directed frame table, corner sequences, and random traffic
// checked against a cycle-count reference model and a loopback serial receiver.
module tb_uart_xmtr;

    localparam int W     = 8;
    localparam int S     = 8;
    localparam int FRAME = (W + 2) * S;

    logic         Sample_clk;
    logic         rst_b;
    logic [W-1:0] Data_bus;
    logic         Load_XMT_datareg;
    logic         Byte_ready;
    logic         Serial_out;
    logic         XMT_busy;
    logic         XMT_done;

    uart_xmtr #(.word_size(W), .samples_per_bit(S)) dut (
        .Sample_clk       (Sample_clk),
        .rst_b            (rst_b),
        .Data_bus         (Data_bus),
        .Load_XMT_datareg (Load_XMT_datareg),
        .Byte_ready       (Byte_ready),
        .Serial_out       (Serial_out),
        .XMT_busy         (XMT_busy),
        .XMT_done         (XMT_done)
    );

    initial Sample_clk = 1'b0;
    always #5 Sample_clk = ~Sample_clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: m_t counts cycles since the accepting edge (-1 when idle).
    int           m_t = -1;
    logic [W-1:0] m_data = '0;
    logic [W-1:0] m_frame = '0;
    logic         m_done = 1'b0;
    logic [W-1:0] exp_q[$];

    always @(posedge Sample_clk) begin
        if (rst_b) begin
            m_t    <= -1;
            m_data <= '0;
            m_done <= 1'b0;
        end else begin
            if (Load_XMT_datareg) m_data <= Data_bus;
            m_done <= (m_t == FRAME);
            if (m_t == 0) m_frame <= m_data;
            if (m_t == FRAME) begin
                m_t <= -1;
                exp_q.push_back(m_frame);
            end else if (m_t >= 0) begin
                m_t <= m_t + 1;
            end else if (Byte_ready) begin
                m_t <= 0;
            end
        end
    end

    // Loopback receiver: mid-bit sampling, flags bad start/stop bits.
    logic         rx_act = 1'b0;
    logic         rx_prev = 1'b1;
    int           rx_cnt = 0;
    logic [W-1:0] rx_byte = '0;
    int           rx_err1 = 0;
    int           rx_err2 = 0;
    logic [W-1:0] rx_q[$];

    always @(negedge Sample_clk) begin
        if (rst_b) begin
            rx_act  <= 1'b0;
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= Serial_out;
            if (!rx_act) begin
                if (rx_prev && !Serial_out) begin
                    rx_act <= 1'b1;
                    rx_cnt <= 1;
                end
            end else begin
                rx_cnt <= rx_cnt + 1;
                if (rx_cnt % S == S / 2) begin
                    if (rx_cnt / S == 0) begin
                        if (Serial_out !== 1'b0) begin
                            rx_err1 <= rx_err1 + 1;
                            rx_act  <= 1'b0;
                        end
                    end else if (rx_cnt / S <= W) begin
                        rx_byte[rx_cnt / S - 1] <= Serial_out;
                    end else begin
                        if (Serial_out !== 1'b1) rx_err2 <= rx_err2 + 1;
                        else rx_q.push_back(rx_byte);
                        rx_act <= 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic frame_bit(input logic [W-1:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= W) return d[idx-1];
        return 1'b1;
    endfunction

    function automatic logic [2:0] model_out();
        logic ln;
        ln = 1'b1;
        if (m_t >= 1 && m_t <= FRAME) ln = frame_bit(m_frame, (m_t - 1) / S);
        return {ln, (m_t >= 0), m_done};
    endfunction

    task automatic check3(input string nm, input logic [2:0] exp);
        n_checks++;
        if ({Serial_out, XMT_busy, XMT_done} !== exp) begin
            n_fail++;
            $display("FAIL %s: line/busy/done=%b required %b at %0t", nm,
                     {Serial_out, XMT_busy, XMT_done}, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Sample_clk);
        #1;
        if (chk_en) check3("monitor", model_out());
    endtask

    // load_mode: 0 none, 1 load one cycle before Byte_ready, 2 load with Byte_ready.
    task automatic send_frame(input int load_mode, input logic [W-1:0] d,
                              input logic [9:0] exp_bits, input int mid_cyc,
                              input logic mid_load, input logic [W-1:0] mid_d,
                              input string nm);
        if (load_mode == 1) begin
            Load_XMT_datareg = 1'b1;
            Data_bus = d;
            tick();
            Load_XMT_datareg = 1'b0;
        end else if (load_mode == 2) begin
            Load_XMT_datareg = 1'b1;
            Data_bus = d;
        end
        Byte_ready = 1'b1;
        tick();
        Byte_ready = 1'b0;
        Load_XMT_datareg = 1'b0;
        check3({nm, "_wait"}, 3'b110);
        for (int j = 1; j <= FRAME; j++) begin
            if (j == mid_cyc) begin
                if (mid_load) begin
                    Load_XMT_datareg = 1'b1;
                    Data_bus = mid_d;
                end else begin
                    Byte_ready = 1'b1;
                end
            end
            tick();
            Load_XMT_datareg = 1'b0;
            Byte_ready = 1'b0;
            check3(nm, {exp_bits[(j - 1) / S], 2'b10});
        end
        tick();
        check3({nm, "_done"}, 3'b101);
        tick();
        check3({nm, "_after"}, 3'b100);
    endtask

    typedef struct {
        int           load_mode;
        logic [W-1:0] data;
        logic [9:0]   exp_bits;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int cyc;
        int base;
        int nmin;

        tbl[0] = '{1, 8'hA5, 10'h34A};
        tbl[1] = '{1, 8'h00, 10'h200};
        tbl[2] = '{2, 8'hFF, 10'h3FE};
        tbl[3] = '{1, 8'h01, 10'h202};
        tbl[4] = '{2, 8'h80, 10'h300};

        rst_b = 1'b1;
        Data_bus = '0;
        Load_XMT_datareg = 1'b0;
        Byte_ready = 1'b0;
        tick();
        tick();
        rst_b = 1'b0;
        chk_en = 1'b1;
        check3("reset", 3'b100);

        for (int i = 0; i < 5; i++)
            send_frame(tbl[i].load_mode, tbl[i].data, tbl[i].exp_bits, 0, 1'b0, 8'h00,
                       $sformatf("vec%0d", i));

        send_frame(1, 8'h3C, 10'h278, 40, 1'b1, 8'hFF, "dbuf_first");
        send_frame(0, 8'h00, 10'h3FE, 0, 1'b0, 8'h00, "dbuf_second");

        send_frame(1, 8'h5A, 10'h2B4, 30, 1'b0, 8'h00, "br_ignored");
        for (int j = 0; j < 10; j++) begin
            tick();
            check3("no_second", 3'b100);
        end

        // Byte_ready held high: two idle-high cycles between frames.
        Load_XMT_datareg = 1'b1;
        Data_bus = 8'h00;
        tick();
        Load_XMT_datareg = 1'b0;
        Byte_ready = 1'b1;
        tick();
        for (int f = 0; f < 2; f++) begin
            for (int j = 1; j <= FRAME; j++) begin
                tick();
                check3("b2b_frame", {(j > FRAME - S) ? 1'b1 : 1'b0, 2'b10});
            end
            tick();
            check3("b2b_gap1", 3'b101);
            tick();
            check3("b2b_gap2", 3'b110);
        end
        Byte_ready = 1'b0;
        tick();
        check3("b2b_start", 3'b010);
        repeat (FRAME + 2) tick();

        // Reset mid-frame, coinciding with a load and a request.
        Load_XMT_datareg = 1'b1;
        Data_bus = 8'hC3;
        tick();
        Load_XMT_datareg = 1'b0;
        Byte_ready = 1'b1;
        tick();
        Byte_ready = 1'b0;
        for (int j = 1; j <= 30; j++) tick();
        rst_b = 1'b1;
        Load_XMT_datareg = 1'b1;
        Data_bus = 8'hFF;
        Byte_ready = 1'b1;
        tick();
        rst_b = 1'b0;
        Load_XMT_datareg = 1'b0;
        Byte_ready = 1'b0;
        check3("rst_mid", 3'b100);
        for (int j = 0; j < 5; j++) begin
            tick();
            check3("rst_idle", 3'b100);
        end
        send_frame(0, 8'h00, 10'h200, 0, 1'b0, 8'h00, "cleared");

        // Random traffic until 256 more frames complete.
        base = exp_q.size();
        cyc = 0;
        while (exp_q.size() < base + 256 && cyc < 40000) begin
            Load_XMT_datareg = ($urandom_range(0, 3) == 0);
            Data_bus = W'($urandom);
            Byte_ready = ($urandom_range(0, 2) == 0);
            tick();
            cyc++;
        end
        Load_XMT_datareg = 1'b0;
        Byte_ready = 1'b0;
        if (cyc >= 40000) begin
            n_checks++;
            n_fail++;
            $display("FAIL rand_budget: %0d frames completed, required %0d",
                     exp_q.size() - base, 256);
        end
        repeat (FRAME + 4) tick();

        check_int("rx_count", rx_q.size(), exp_q.size());
        nmin = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++)
            check_int($sformatf("rx_byte%0d", i), int'(rx_q[i]), int'(exp_q[i]));
        check_int("rx_err1", rx_err1, 0);
        check_int("rx_err2", rx_err2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
